// File: rtl/types_pkg.sv
// Shared types for the load/store path.
//   XLEN        datapath width in bits
//   word_t      one XLEN-bit data word
//   be_t        per-byte enable vector, bit i covers bits [8i+7:8i]
//   mem_state_t responder FSM state
package types_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [XLEN/8-1:0] be_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/data_mem_responder_sp_ram.sv
// sp_ram: single-port synchronous RAM, per-byte write enable, registered read.
//   clk    system clock
//   en     access strobe; read data register and writes update only when set
//   we     write the bytes selected by be
//   be     byte enables
//   addr   word index
//   wdata  write data
//   rdata  registered read data (value before any same-cycle write)
module sp_ram
  import types_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  be_t           be,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < XLEN/8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the core's load/store port.
// Accepts one request at a time, waits WAIT_CYCLES, then returns a single-cycle
// response. Stores commit and loads sample the RAM on the edge entering RESP.
//   clk        system clock
//   Reset      asynchronous active-low reset
//   req_*      request handshake and fields (sampled only at the accept edge)
//   rsp_valid  one-cycle response strobe
//   rsp_rdata  load data, zero for stores and errors
//   rsp_err    misaligned or out-of-range address
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request latched, counting down wait states
// RESP  | response presented for one cycle
module data_mem_responder
  import types_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic  clk,
  input  logic  Reset,
  input  logic  req_valid,
  output logic  req_ready,
  input  logic  req_we,
  input  word_t req_addr,
  input  word_t req_wdata,
  input  be_t   req_be,
  output logic  rsp_valid,
  output word_t rsp_rdata,
  output logic  rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_t    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, err_q;
  logic [AW-1:0] idx_q;
  word_t         wdata_q;
  be_t           be_q;

  logic          req_err;
  logic          accept;
  logic          use_req;
  logic          ram_en;
  logic          cur_we, cur_err;
  logic [AW-1:0] cur_idx;
  word_t         cur_wdata;
  be_t           cur_be;
  word_t         ram_rdata;

  // Upper address bits beyond the RAM are an error, never a wrap.
  assign req_err = (req_addr[1:0] != 2'b00) || (|req_addr[XLEN-1:AW+2]);
  assign accept  = req_valid && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= req_err;
        idx_q   <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // With zero wait states IDLE goes straight to RESP, so the RAM must see the
  // live request fields on that edge rather than the not-yet-latched copies.
  assign use_req   = (state_q == IDLE);
  assign cur_we    = use_req ? req_we           : we_q;
  assign cur_err   = use_req ? req_err          : err_q;
  assign cur_idx   = use_req ? req_addr[AW+1:2] : idx_q;
  assign cur_wdata = use_req ? req_wdata        : wdata_q;
  assign cur_be    = use_req ? req_be           : be_q;

  // The RAM has no reset; gating with Reset keeps a request presented during
  // reset from writing it.
  assign ram_en = Reset && (state_d == RESP) && (state_q != RESP);

  sp_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (cur_we && !cur_err),
    .be    (cur_be),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : '0;

endmodule
